mem_lsu_port: RTL and testbench
===============================

MEM_LSU_PORT -- requirements
Module: mem_lsu_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 21, the byte-address width of the attached memory (2^21 bytes).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the data width; only 64 is supported.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows:
- clk  in  1  clock, all state on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when high together with req_valid
- req_addr  in  ADDR_WIDTH  byte address, any alignment
- req_wen  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_wdata  in  64  store data, little-endian from req_addr
- resp_valid  out  1  response held
- resp_ready  in  1  response consumed when high together with resp_valid
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  out-of-range request
- mem_w_addr  out  ADDR_WIDTH  memory write address
- mem_w_data  out  64  memory write data
- mem_w_mask  out  8  memory byte-write mask
- mem_w_en  out  1  memory write enable
- mem_r_addr  out  ADDR_WIDTH  memory read address; the memory registers it
- mem_r_data  in  64  memory read data, valid in the cycle after mem_r_addr is sampled

Function
REQ-005 The block SHALL have exactly three states: IDLE, LOAD_WAIT and RESP, with one request outstanding at most.
REQ-006 req_ready SHALL be 1 in IDLE, equal to resp_ready in RESP, 0 in LOAD_WAIT and 0 while reset is high.
REQ-007 A request SHALL be accepted in a cycle where req_valid and req_ready are both 1.
REQ-008 Request length SHALL be 1 << req_size bytes; the request is in error when req_addr + length > 2^ADDR_WIDTH, computed at ADDR_WIDTH+1 bits.
REQ-009 mem_w_mask SHALL be 0x01, 0x03, 0x0F or 0xFF for req_size 0, 1, 2, 3 respectively.
REQ-010 mem_w_addr SHALL equal req_addr and mem_w_data SHALL equal req_wdata, combinationally.
REQ-011 mem_w_en SHALL be 1 only in the accept cycle of a store without error, so the memory writes on that edge.
REQ-012 mem_r_addr SHALL equal req_addr combinationally at all times.
REQ-013 An accepted store, or any accepted errored request, SHALL go to RESP; resp_valid is 1 on the next cycle (latency 1), with resp_rdata 0 and resp_err equal to the error flag.
REQ-014 An accepted load without error SHALL go to LOAD_WAIT, holding its size and signed flag in registers.
REQ-015 In LOAD_WAIT the block SHALL register the extended mem_r_data into resp_rdata with resp_err 0 and go to RESP, so resp_valid is 1 two cycles after accept.
REQ-016 Extension SHALL take bits [8*length-1:0] of mem_r_data and fill the upper bits with the top bit (req_signed 1) or with 0 (req_signed 0); size 3 passes all 64 bits.
REQ-017 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready is 1.
REQ-018 In RESP with resp_ready 1 and no new accept, the block SHALL go to IDLE and drop resp_valid on the next cycle.
REQ-019 In RESP with resp_ready 1 and a new accept in the same cycle, the new request SHALL proceed per REQ-013/014; a store or error reloads RESP back-to-back, with no bubble in resp_valid.
REQ-020 resp_valid SHALL be 0 in IDLE and LOAD_WAIT.
REQ-021 An errored store SHALL never assert mem_w_en.

Reset
REQ-022 When reset is high at a clock edge, the state SHALL become IDLE, resp_valid 0, resp_rdata 0 and resp_err 0.
REQ-023 mem_w_en SHALL be 0 during any cycle in which reset is high.
REQ-024 A reset while in LOAD_WAIT or RESP SHALL drop the in-flight request without any response.

Verification
REQ-025 The bench SHALL cover: store addr 0x100, size 3, wdata 0x1122334455667788 -> mask 0xFF and mem_w_en for 1 cycle; resp_valid next cycle with rdata 0 and err 0.
REQ-026 The bench SHALL cover: memory at 0x100 holds byte 0x88, then load size 0 with signed 1 -> resp_rdata 0xFFFFFFFFFFFFFF88 two cycles after accept; the same load with signed 0 -> 0x88.
REQ-027 The bench SHALL cover: load addr 0x1FFFFE, size 2 -> resp_err 1, rdata 0, latency 1; the same as a store -> mem_w_en never asserted.
REQ-028 The bench SHALL cover: resp_ready held 0 for 5 cycles -> response held stable and req_ready 0; then resp_ready 1 with a new store offered -> accepted the same cycle, and resp_valid stays 1 with no gap.
REQ-029 The bench SHALL cover: unaligned half store at 0x103 of 0xBEEF, then a half load at 0x103 with signed 0 -> resp_rdata 0xBEEF.
REQ-030 The bench SHALL cover: reset asserted in LOAD_WAIT -> next cycle IDLE, resp_valid 0, req_ready 1 once reset is low.

Source files
------------

// File: rtl/mem_lsu_port.sv
// Load/store port onto a byte-masked 64-bit memory with a registered read address.
// One request in flight; sub-word loads are sign- or zero-extended into resp_rdata.
module mem_lsu_port #(
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      req_wen,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic [ADDR_WIDTH-1:0]     mem_w_addr,
  output logic [DATA_WIDTH-1:0]     mem_w_data,
  output logic [DATA_WIDTH/8-1:0]   mem_w_mask,
  output logic                      mem_w_en,
  output logic [ADDR_WIDTH-1:0]     mem_r_addr,
  input  logic [DATA_WIDTH-1:0]     mem_r_data
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned AW1        = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] MEM_BYTES = AW1'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic [AW1-1:0]          req_len;
  logic [AW1-1:0]          req_end;
  logic                    req_err;

  function automatic logic [DATA_WIDTH-1:0] extend(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [1:0]            size,
    input logic                  sgn
  );
    logic [DATA_WIDTH-1:0] res;
    res = raw;
    case (size)
      2'd0:    res = {{(DATA_WIDTH-8){sgn & raw[7]}},   raw[7:0]};
      2'd1:    res = {{(DATA_WIDTH-16){sgn & raw[15]}}, raw[15:0]};
      2'd2:    res = {{(DATA_WIDTH-32){sgn & raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Range check at one extra bit so a request ending exactly at the top is legal.
  assign req_len = AW1'(1) << req_size;
  assign req_end = {1'b0, req_addr} + req_len;
  assign req_err = req_end > MEM_BYTES;

  assign mem_w_addr = req_addr;
  assign mem_w_data = req_wdata;
  assign mem_r_addr = req_addr;

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      size_q   <= 2'd0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    signed_d = signed_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      if (req_wen || req_err) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = req_err;
      end else begin
        state_d  = LOAD_WAIT;
        size_d   = req_size;
        signed_d = req_signed;
      end
    end else begin
      case (state_q)
        LOAD_WAIT: begin
          state_d = RESP;
          rdata_d = extend(mem_r_data, size_q, signed_q);
          err_d   = 1'b0;
        end
        RESP: begin
          if (resp_ready) state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: req_ready = ~reset;
      RESP: begin
        req_ready  = resp_ready & ~reset;
        resp_valid = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
    accept   = req_valid & req_ready;
    mem_w_en = accept & req_wen & ~req_err;
    case (req_size)
      2'd0:    mem_w_mask = STRB_WIDTH'(8'h01);
      2'd1:    mem_w_mask = STRB_WIDTH'(8'h03);
      2'd2:    mem_w_mask = STRB_WIDTH'(8'h0F);
      default: mem_w_mask = STRB_WIDTH'(8'hFF);
    endcase
  end

endmodule

// File: tb/tb_mem_lsu_port.sv
// Bench for mem_lsu_port: byte-addressed memory stub, a transaction-level reference
// model checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_lsu_port;

  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_wen;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [63:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_w_addr;
  logic [63:0]   mem_w_data;
  logic [7:0]    mem_w_mask;
  logic          mem_w_en;
  logic [AW-1:0] mem_r_addr;
  logic [63:0]   mem_r_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_lsu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask), .mem_w_en(mem_w_en),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory stub driven only by the DUT's memory pins.
  logic [7:0] phys [int];

  always @(posedge clk) begin
    logic [63:0] r;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = phys.exists(int'(mem_r_addr) + i) ? phys[int'(mem_r_addr) + i] : 8'h00;
    mem_r_data <= r;
    if (mem_w_en === 1'b1)
      for (int i = 0; i < 8; i++)
        if (mem_w_mask[i]) phys[int'(mem_w_addr) + i] = mem_w_data[8*i +: 8];
  end

  // Reference model: memory contents from accepted requests, plus the response in flight.
  logic [7:0]  ref_mem [int];
  logic        m_valid = 1'b0;
  logic        m_wait  = 1'b0;
  logic [63:0] m_rdata = '0;
  logic        m_err   = 1'b0;
  logic [63:0] m_load_val = '0;

  function automatic logic [63:0] ref_read(input int a);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem.exists(a + i) ? ref_mem[a + i] : 8'h00;
    return r;
  endfunction

  function automatic logic [63:0] ext_ref(input logic [63:0] raw, input int size, input logic sgn);
    int nb;
    logic [63:0] m;
    logic [63:0] v;
    nb = 8 << size;
    if (nb >= 64) return raw;
    m = (64'd1 << nb) - 64'd1;
    v = raw & m;
    if (sgn && raw[nb-1]) v = v | ~m;
    return v;
  endfunction

  initial begin
    logic        exp_ready, acc, e, exp_wen;
    int          len;
    logic [7:0]  exp_mask;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ready = !reset && ((!m_valid && !m_wait) || (m_valid && resp_ready));
      acc       = req_valid && exp_ready;
      len       = 1 << int'(req_size);
      e         = (longint'(req_addr) + longint'(len)) > (longint'(1) << AW);
      exp_wen   = acc && req_wen && !e;
      exp_mask  = 8'((16'd1 << len) - 16'd1);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("resp_valid", 64'(resp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 64'(resp_err), 64'(m_err));
      end
      chk("mem_w_en", 64'(mem_w_en), 64'(exp_wen));
      chk("mem_r_addr", 64'(mem_r_addr), 64'(req_addr));
      if (exp_wen) begin
        chk("mem_w_mask", 64'(mem_w_mask), 64'(exp_mask));
        chk("mem_w_addr", 64'(mem_w_addr), 64'(req_addr));
        chk("mem_w_data", mem_w_data, req_wdata);
      end
      if (reset) begin
        m_valid = 1'b0; m_wait = 1'b0; m_rdata = '0; m_err = 1'b0;
      end else begin
        if (m_wait) begin
          m_wait = 1'b0; m_valid = 1'b1; m_rdata = m_load_val; m_err = 1'b0;
        end else if (m_valid && resp_ready) begin
          m_valid = 1'b0;
        end
        if (acc) begin
          if (req_wen || e) begin
            if (!e)
              for (int i = 0; i < len; i++) ref_mem[int'(req_addr) + i] = req_wdata[8*i +: 8];
            m_valid = 1'b1; m_rdata = '0; m_err = e;
          end else begin
            m_wait = 1'b1; m_valid = 1'b0;
            m_load_val = ext_ref(ref_read(int'(req_addr)), int'(req_size), req_signed);
          end
        end
      end
    end
  end

  logic       acc_wen;
  logic [7:0] acc_mask;

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic wen, input logic [AW-1:0] addr, input logic [1:0] size,
                      input logic sgn, input logic [63:0] wdata);
    logic got;
    got = 1'b0;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wdata;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = req_ready;
      acc_wen = mem_w_en;
      acc_mask = mem_w_mask;
      @(posedge clk); #1;
    end
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
    req_valid = 1'b0;
  endtask

  // Returns at the falling edge where resp_valid is first seen.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) return;
    end
    chk("resp_timeout", 64'(resp_valid), 64'd1);
  endtask

  initial begin
    int lat;
    int sel;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = '0; resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(req_ready), 64'd1);
    chk("post_rst_rdata", resp_rdata, 64'd0);
    chk("post_rst_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;

    // Full-width store.
    send(1'b1, 21'h100, 2'd3, 1'b0, 64'h1122334455667788);
    chk("st_wen", 64'(acc_wen), 64'd1);
    chk("st_mask", 64'(acc_mask), 64'hFF);
    wait_resp(lat);
    chk("st_lat", 64'(lat), 64'd1);
    chk("st_rdata", resp_rdata, 64'd0);
    chk("st_err", 64'(resp_err), 64'd0);
    chk("st_wen_one_cycle", 64'(mem_w_en), 64'd0);
    @(posedge clk); #1;

    // Byte loads, signed then unsigned.
    send(1'b0, 21'h100, 2'd0, 1'b1, 64'd0);
    wait_resp(lat);
    chk("ldb_s_lat", 64'(lat), 64'd2);
    chk("ldb_s_rdata", resp_rdata, 64'hFFFFFFFFFFFFFF88);
    @(posedge clk); #1;
    send(1'b0, 21'h100, 2'd0, 1'b0, 64'd0);
    wait_resp(lat);
    chk("ldb_u_rdata", resp_rdata, 64'h88);
    @(posedge clk); #1;

    // Out-of-range word at the top of memory.
    send(1'b0, 21'h1FFFFE, 2'd2, 1'b0, 64'd0);
    wait_resp(lat);
    chk("err_ld_lat", 64'(lat), 64'd1);
    chk("err_ld_err", 64'(resp_err), 64'd1);
    chk("err_ld_rdata", resp_rdata, 64'd0);
    @(posedge clk); #1;
    send(1'b1, 21'h1FFFFE, 2'd2, 1'b0, 64'hDEADBEEF);
    chk("err_st_wen", 64'(acc_wen), 64'd0);
    wait_resp(lat);
    chk("err_st_err", 64'(resp_err), 64'd1);
    @(posedge clk); #1;

    // Backpressure: response held, then back-to-back accept with no bubble.
    resp_ready = 1'b0;
    send(1'b0, 21'h100, 2'd3, 1'b0, 64'd0);
    wait_resp(lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 21'h200; req_size = 2'd3;
    req_wdata = 64'hCAFEF00D12345678;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, 64'h1122334455667788);
      chk("hold_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_ready", 64'(req_ready), 64'd1);
    chk("b2b_wen", 64'(mem_w_en), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", 64'(resp_valid), 64'd1);
    chk("b2b_rdata", resp_rdata, 64'd0);
    @(posedge clk); #1;

    // Unaligned half store then load.
    send(1'b1, 21'h103, 2'd1, 1'b0, 64'hBEEF);
    wait_resp(lat);
    @(posedge clk); #1;
    send(1'b0, 21'h103, 2'd1, 1'b0, 64'd0);
    wait_resp(lat);
    chk("half_rdata", resp_rdata, 64'hBEEF);
    @(posedge clk); #1;

    // Reset during LOAD_WAIT drops the load.
    send(1'b0, 21'h100, 2'd3, 1'b0, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rlw_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rlw_valid", 64'(resp_valid), 64'd0);
      chk("rlw_idle_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      resp_ready = ($urandom_range(0, 9) < 7);
      req_valid  = ($urandom_range(0, 9) < 6);
      req_wen    = $urandom_range(0, 1) == 1;
      req_size   = 2'($urandom_range(0, 3));
      req_signed = $urandom_range(0, 1) == 1;
      req_wdata  = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel < 7)      req_addr = 21'h100 + 21'($urandom_range(0, 63));
      else if (sel < 9) req_addr = 21'h1FFFF0 + 21'($urandom_range(0, 15));
      else              req_addr = 21'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
